// File: rtl/fifo_pkg.sv
// Shared sizing helpers and parameter sanity functions for the level-reporting FIFO.
package fifo_pkg;

  function automatic int lvl_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit thr_ok(input int lvl, input int depth);
    return (lvl >= 0) && (lvl <= depth);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int PW    = 3
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [PW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [PW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_level.sv
// Parametrised valid/ready FIFO with fill level, almost-full/empty flags,
// synchronous flush and optional empty fall-through.
module fifo_level
  import fifo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 8,
  parameter int AFULL_LVL  = DEPTH - 2,
  parameter int AEMPTY_LVL = 1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [WIDTH-1:0]                 in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [WIDTH-1:0]                 out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [lvl_width(DEPTH)-1:0]      level,
  output logic                             almost_full,
  output logic                             almost_empty
);

  localparam int LW = lvl_width(DEPTH);
  localparam int PW = ptr_width(DEPTH);
  localparam logic [LW-1:0] LVL_FULL   = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AFULL  = LW'(AFULL_LVL);
  localparam logic [LW-1:0] LVL_AEMPTY = LW'(AEMPTY_LVL);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("fifo_level: DEPTH must be a power of two >= 2");
  end
  if (!thr_ok(AFULL_LVL, DEPTH) || !thr_ok(AEMPTY_LVL, DEPTH)) begin : g_bad_thr
    $error("fifo_level: AFULL_LVL and AEMPTY_LVL must lie in 0..DEPTH");
  end

  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic [WIDTH-1:0] w_rd_data;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_bypass;
  logic             w_wr;
  logic             w_rd;

  assign w_full  = (r_level == LVL_FULL);
  assign w_empty = (r_level == {LW{1'b0}});

  assign in_ready  = ~rst & ~flush & (~w_full | out_ready);
  assign out_valid = ~rst & ~flush & (~w_empty | (BYPASS & in_valid));

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  // A word handed straight through an empty FIFO never touches storage.
  assign w_bypass = BYPASS & w_empty & w_push & w_pop;
  assign w_wr     = w_push & ~w_bypass;
  assign w_rd     = w_pop & ~w_bypass;

  assign out_data     = (BYPASS && w_empty) ? in_data : w_rd_data;
  assign level        = r_level;
  assign almost_full  = (r_level >= LVL_AFULL);
  assign almost_empty = (r_level <= LVL_AEMPTY);

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (r_wptr),
    .i_wdata (in_data),
    .i_raddr (r_rptr),
    .o_rdata (w_rd_data)
  );

  // Pointers and level counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_level <= {LW{1'b0}};
    end else if (flush) begin
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_level <= {LW{1'b0}};
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_rd) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_level.sv
// Directed bench for fifo_level: a BYPASS=0 instance driven from a vector table,
// a BYPASS=1 instance and asynchronous reset exercised by short hand-written sequences.
module tb_fifo_level;

  logic       clk;
  logic       rst;

  logic       a_flush, a_iv, a_ir, a_ov, a_or, a_af, a_ae;
  logic [7:0] a_id, a_od;
  logic [3:0] a_lvl;

  logic       b_flush, b_iv, b_ir, b_ov, b_or, b_af, b_ae;
  logic [7:0] b_id, b_od;
  logic [3:0] b_lvl;

  int checks = 0;
  int errors = 0;

  fifo_level #(.WIDTH(8), .DEPTH(8), .AFULL_LVL(6), .AEMPTY_LVL(1), .BYPASS(1'b0)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_data(a_id), .in_valid(a_iv), .in_ready(a_ir),
    .out_data(a_od), .out_valid(a_ov), .out_ready(a_or),
    .level(a_lvl), .almost_full(a_af), .almost_empty(a_ae)
  );

  fifo_level #(.WIDTH(8), .DEPTH(8), .AFULL_LVL(6), .AEMPTY_LVL(1), .BYPASS(1'b1)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_data(b_id), .in_valid(b_iv), .in_ready(b_ir),
    .out_data(b_od), .out_valid(b_ov), .out_ready(b_or),
    .level(b_lvl), .almost_full(b_af), .almost_empty(b_ae)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       orr;
    logic       fl;
    logic       e_ov;
    logic [7:0] e_od;
    logic       e_ir;
    logic [3:0] e_lvl;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic iv, input logic [7:0] id, input logic orr,
                              input logic fl, input logic e_ov, input logic [7:0] e_od,
                              input logic e_ir, input logic [3:0] e_lvl);
    vec_t v;
    v.iv = iv; v.id = id; v.orr = orr; v.fl = fl;
    v.e_ov = e_ov; v.e_od = e_od; v.e_ir = e_ir; v.e_lvl = e_lvl;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle_a();
    a_iv = 1'b0; a_id = 8'h00; a_or = 1'b0; a_flush = 1'b0;
  endtask

  task automatic push_a(input logic [7:0] d);
    @(negedge clk);
    a_iv = 1'b1; a_id = d; a_or = 1'b0; a_flush = 1'b0;
  endtask

  initial begin
    logic [7:0] d;

    // Vector table for the registered-path instance
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0);
    add(1'b1, 8'hfe, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0);
    for (int k = 1; k < 8; k++) begin
      d = 8'(8'hfe - k * 8'h11);
      add(1'b1, d, 1'b0, 1'b0, 1'b1, 8'hfe, 1'b1, 4'(k));
    end
    add(1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 8'hfe, 1'b0, 4'd8);
    add(1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 8'hfe, 1'b1, 4'd8);
    for (int j = 0; j < 8; j++) begin
      d = (j < 7) ? 8'(8'hed - j * 8'h11) : 8'h01;
      add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, d, 1'b1, 4'(8 - j));
    end
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0);
    // Wrap-around at constant level 3
    add(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0);
    add(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h10, 1'b1, 4'd1);
    add(1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 8'h10, 1'b1, 4'd2);
    for (int i = 0; i < 20; i++) begin
      add(1'b1, 8'(8'h13 + i), 1'b1, 1'b0, 1'b1, 8'(8'h10 + i), 1'b1, 4'd3);
    end
    for (int i = 20; i < 23; i++) begin
      add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'(8'h10 + i), 1'b1, 4'(23 - i));
    end
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0);
    // Flush at level 5 with both sides requesting
    add(1'b1, 8'ha0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0);
    for (int k = 1; k < 5; k++) begin
      add(1'b1, 8'(8'ha0 + k), 1'b0, 1'b0, 1'b1, 8'ha0, 1'b1, 4'(k));
    end
    add(1'b1, 8'hee, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 4'd5);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0);
    add(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 4'd1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0);

    rst = 1'b1;
    idle_a();
    b_iv = 1'b0; b_id = 8'h00; b_or = 1'b0; b_flush = 1'b0;

    #3;
    chk("rst_a_lvl", a_lvl, 4'd0);
    chk("rst_a_ov", a_ov, 1'b0);
    chk("rst_a_ir", a_ir, 1'b0);
    chk("rst_a_ae", a_ae, 1'b1);
    chk("rst_a_af", a_af, 1'b0);
    chk("rst_b_ov", b_ov, 1'b0);
    chk("rst_b_ir", b_ir, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      a_iv = vecs[i].iv; a_id = vecs[i].id; a_or = vecs[i].orr; a_flush = vecs[i].fl;
      #1;
      chk($sformatf("v%0d_ov", i), a_ov, vecs[i].e_ov);
      if (vecs[i].e_ov) chk($sformatf("v%0d_od", i), a_od, vecs[i].e_od);
      chk($sformatf("v%0d_ir", i), a_ir, vecs[i].e_ir);
      chk($sformatf("v%0d_lvl", i), a_lvl, vecs[i].e_lvl);
      chk($sformatf("v%0d_af", i), a_af, (vecs[i].e_lvl >= 4'd6));
      chk($sformatf("v%0d_ae", i), a_ae, (vecs[i].e_lvl <= 4'd1));
    end
    @(negedge clk);
    idle_a();

    // Fall-through instance: pass-through with consumer ready, then store with it stalled
    @(negedge clk);
    b_iv = 1'b1; b_id = 8'h54; b_or = 1'b1;
    #1;
    chk("byp_ov", b_ov, 1'b1);
    chk("byp_od", b_od, 8'h54);
    chk("byp_lvl_pre", b_lvl, 4'd0);
    @(negedge clk);
    b_or = 1'b0;
    #1;
    chk("byp_lvl_post", b_lvl, 4'd0);
    chk("byp_stall_od", b_od, 8'h54);
    @(negedge clk);
    b_iv = 1'b0; b_id = 8'h00; b_or = 1'b1;
    #1;
    chk("byp_store_lvl", b_lvl, 4'd1);
    chk("byp_store_ov", b_ov, 1'b1);
    chk("byp_store_od", b_od, 8'h54);
    @(negedge clk);
    b_or = 1'b0;
    #1;
    chk("byp_drain_lvl", b_lvl, 4'd0);
    chk("byp_drain_ov", b_ov, 1'b0);

    // Asynchronous reset between edges at level 4
    for (int k = 0; k < 4; k++) push_a(8'(8'hc0 + k));
    @(negedge clk);
    idle_a();
    a_or = 1'b1;
    #1;
    chk("pre_rst_lvl", a_lvl, 4'd4);
    chk("pre_rst_ov", a_ov, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_ov", a_ov, 1'b0);
    chk("mid_rst_lvl", a_lvl, 4'd0);
    chk("mid_rst_ir", a_ir, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    a_or = 1'b0;
    #1;
    chk("post_rst_ir", a_ir, 1'b1);
    chk("post_rst_ov", a_ov, 1'b0);
    push_a(8'h3c);
    @(negedge clk);
    idle_a();
    #1;
    chk("post_rst_lvl", a_lvl, 4'd1);
    chk("post_rst_od", a_od, 8'h3c);
    chk("post_rst_ov1", a_ov, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
